// File: rtl/reg_file.sv
// 32 x DATA_W register file: two combinational read ports and one clocked write port. Reg 0 reads zero and reg 29 resets to SP_INIT.
// Reads take 0 cycles and writes take 1 edge; there is no backpressure. Define REG_FILE_BYPASS_EN for write-first reads.
module reg_file #(
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] SP_INIT = 32'd128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        RSaddr_i,
  input  logic [4:0]        RTaddr_i,
  input  logic [4:0]        RDaddr_i,
  input  logic [DATA_W-1:0] RDdata_i,
  input  logic              RegWrite_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o
);

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned SP_IDX   = 29;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wr_vld;

  // Reg 0 is never written, so its flop holds the reset value of zero forever.
  assign wr_vld = RegWrite_i && (RDaddr_i != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_vld) begin
      regs_d[RDaddr_i] = RDdata_i;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    RSdata_o = (RSaddr_i == 5'd0) ? '0 : regs_q[RSaddr_i];
    RTdata_o = (RTaddr_i == 5'd0) ? '0 : regs_q[RTaddr_i];
`ifdef REG_FILE_BYPASS_EN
    // Forward the in-flight write so that a same-cycle reader sees the new value.
    if (wr_vld && !rst_i && (RSaddr_i == RDaddr_i)) begin
      RSdata_o = RDdata_i;
    end
    if (wr_vld && !rst_i && (RTaddr_i == RDaddr_i)) begin
      RTdata_o = RDdata_i;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: it covers reset, writes, reg 0, reset priority, same-address reads and a full sweep.
module tb_reg_file;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  RSaddr_i;
  logic [4:0]  RTaddr_i;
  logic [4:0]  RDaddr_i;
  logic [31:0] RDdata_i;
  logic        RegWrite_i;
  logic [31:0] RSdata_o;
  logic [31:0] RTdata_o;

  int checks = 0;
  int errors = 0;

`ifdef REG_FILE_BYPASS_EN
  localparam logic [31:0] SAME_ADDR_PRE = 32'h2;
`else
  localparam logic [31:0] SAME_ADDR_PRE = 32'h1;
`endif

  reg_file #(.DATA_W(32), .SP_INIT(32'd128)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .RSaddr_i   (RSaddr_i),
    .RTaddr_i   (RTaddr_i),
    .RDaddr_i   (RDaddr_i),
    .RDdata_i   (RDdata_i),
    .RegWrite_i (RegWrite_i),
    .RSdata_o   (RSdata_o),
    .RTdata_o   (RTdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle just past it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [4:0] rs, input logic [4:0] rt);
    RSaddr_i = rs;
    RTaddr_i = rt;
    #1;
  endtask

  initial begin
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;

    rst_i = 1'b1; RegWrite_i = 1'b0; RDaddr_i = '0; RDdata_i = '0;
    RSaddr_i = '0; RTaddr_i = '0;
    tick();
    rst_i = 1'b0;

    rd(5'd0, 5'd1);
    chk("rst_r0", RSdata_o, 32'h0);
    chk("rst_r1", RTdata_o, 32'h0);
    rd(5'd29, 5'd31);
    chk("rst_sp", RSdata_o, 32'd128);
    chk("rst_r31", RTdata_o, 32'h0);

    RegWrite_i = 1'b1; RDaddr_i = 5'd5; RDdata_i = 32'hDEADBEEF;
    tick();
    RegWrite_i = 1'b0;
    rd(5'd5, 5'd5);
    chk("wr5_rs", RSdata_o, 32'hDEADBEEF);
    chk("wr5_rt", RTdata_o, 32'hDEADBEEF);

    RegWrite_i = 1'b1; RDaddr_i = 5'd0; RDdata_i = 32'hFFFFFFFF;
    rd(5'd0, 5'd0);
    chk("r0_pre_rs", RSdata_o, 32'h0);
    tick();
    RegWrite_i = 1'b0;
    rd(5'd0, 5'd0);
    chk("r0_rs", RSdata_o, 32'h0);
    chk("r0_rt", RTdata_o, 32'h0);

    RegWrite_i = 1'b1; RDaddr_i = 5'd29; RDdata_i = 32'h0000ABCD;
    tick();
    RegWrite_i = 1'b0;
    rd(5'd29, 5'd5);
    chk("wr_sp", RSdata_o, 32'h0000ABCD);
    chk("keep5", RTdata_o, 32'hDEADBEEF);

    rst_i = 1'b1; RegWrite_i = 1'b1; RDaddr_i = 5'd7; RDdata_i = 32'h12345678;
    tick();
    rst_i = 1'b0; RegWrite_i = 1'b0;
    rd(5'd7, 5'd29);
    chk("rstpri_r7", RSdata_o, 32'h0);
    chk("rstpri_sp", RTdata_o, 32'd128);
    rd(5'd5, 5'd5);
    chk("rstpri_r5", RSdata_o, 32'h0);

    RegWrite_i = 1'b1; RDaddr_i = 5'd9; RDdata_i = 32'h1;
    tick();
    RDdata_i = 32'h2;
    rd(5'd9, 5'd8);
    chk("same_pre_rs", RSdata_o, SAME_ADDR_PRE);
    chk("same_pre_other", RTdata_o, 32'h0);
    tick();
    RegWrite_i = 1'b0;
    rd(5'd9, 5'd9);
    chk("same_post_rs", RSdata_o, 32'h2);
    chk("same_post_rt", RTdata_o, 32'h2);

    for (int i = 1; i < 32; i++) begin
      RegWrite_i = 1'b1; RDaddr_i = 5'(i); RDdata_i = 32'(i) * 32'h01010101;
      tick();
    end
    RegWrite_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i));
      exp_rs = 32'(i) * 32'h01010101;
      exp_rt = 32'(31 - i) * 32'h01010101;
      chk($sformatf("sweep_rs%0d", i), RSdata_o, exp_rs);
      chk($sformatf("sweep_rt%0d", 31 - i), RTdata_o, exp_rt);
    end

    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    rd(5'd29, 5'd31);
    chk("rst2_sp", RSdata_o, 32'd128);
    chk("rst2_r31", RTdata_o, 32'h0);
    rd(5'd1, 5'd16);
    chk("rst2_r1", RSdata_o, 32'h0);
    chk("rst2_r16", RTdata_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

General-purpose register file for the single-cycle MIPS-style datapath: 32 registers of 32 bits, two combinational read ports, one clocked write port. The read ports drive the ALU operand inputs, directly or through the operand mux. The write port takes the write-back value (ALU result or memory data) from downstream. Register 0 is hardwired to zero. The stack pointer has a configurable reset value.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- SP_INIT, 32'd128, reset value of register 29 ($sp)

Ports (one clock; reset is synchronous and active-high):
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  synchronous active-high reset
- RSaddr_i  input  5  read port 1 address (rs)
- RTaddr_i  input  5  read port 2 address (rt)
- RDaddr_i  input  5  write address (rd/rt, after RegDst mux)
- RDdata_i  input  DATA_W  write data
- RegWrite_i  input  1  write enable
- RSdata_o  output  DATA_W  read data, port 1 (to ALU src1)
- RTdata_o  output  DATA_W  read data, port 2 (to ALU src2 / mem write data)

## Operation
- Storage: 32 x DATA_W flops, indices 0..31.
- Reset, when rst_i=1 at a rising edge:
  - all registers are set to 0, except reg 29, which is set to SP_INIT.
  - rst_i has priority over RegWrite_i. A write presented in the same cycle is dropped.
- Write: when rst_i=0 and RegWrite_i=1 at a rising edge, reg[RDaddr_i] <= RDdata_i.
  - A write to address 0 is ignored; reg 0 stays 0.
  - A write to reg 29 is an ordinary write.
- Read: combinational. RSdata_o = reg[RSaddr_i] and RTdata_o = reg[RTaddr_i].
  - Address 0 always reads 0.
  - Both ports may read the same address.
- Any address value is legal (5-bit, no out-of-range case).

## Timing
- Read latency: 0 cycles (combinational from address and register state).
- Write latency: 1 edge. The new value is visible on the read ports right after the rising edge that commits it.
- Reset mid-operation: asserting rst_i on any edge forces the reset state at that edge. The outputs reflect reset contents (0, or SP_INIT for address 29) combinationally after that edge.
- Output values after reset: RSdata_o/RTdata_o = 0 for any address except 29, which gives SP_INIT.
- Same-cycle read/write of the same address (non-zero, no bypass): the read returns the old value until the edge, then the new value.
- The block contains no combinational path from RDdata_i/RegWrite_i to the outputs unless bypass is compiled in.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - Each read port returns RDdata_i combinationally when all of the following hold: RegWrite_i=1, rst_i=0, the read address equals RDaddr_i, and RDaddr_i != 0 (write-first behaviour).
  - Address 0 still reads 0.
  - No bypass while rst_i=1.
- REG_FILE_BYPASS_EN undefined:
  - Reads are purely from storage (read-first behaviour). This is the default build.

## Test plan
- Reset -> pulse rst_i for 1 edge. Read addresses 0, 1, 29, 31 -> 0, 0, 128, 0.
- Basic write/read -> write 0xDEADBEEF to reg 5 (RegWrite_i=1, one edge). Set RSaddr_i=5 and RTaddr_i=5 -> both outputs 0xDEADBEEF.
- Reg 0 immutability -> write 0xFFFFFFFF to address 0. Read address 0 on both ports -> 0.
- Reset priority -> with rst_i=1, also write 0x12345678 to reg 7 at the same edge. Read reg 7 -> 0; reg 29 -> 128.
- Same-address read during write -> reg 9=0x1, and write 0x2 to reg 9 while RSaddr_i=9. Before the edge: 0x1 (no bypass) or 0x2 (with REG_FILE_BYPASS_EN). After the edge: 0x2 in both builds.
- Full sweep -> write value (i*0x01010101) to each reg i=1..31 over 31 cycles. Read all pairs (i, 31-i) -> the expected values; reg 0 reads 0.
